// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU, W-bit operands, 2W-bit registered result.
// Define SEQ_ALU_MOD_EN to build the iterative modulo datapath for op 110.
module seq_alu #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] alu,
  output logic           parity,
  output logic           err
);

  localparam int unsigned SW = $clog2(W);
  localparam int unsigned CW = SW + 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMul  = 3'd1;
  localparam logic [2:0] StRot  = 3'd2;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] MulLast = CW'(W - 1);
  localparam logic [CW:0]   RotFull = (CW + 1)'(2 * W);

  logic [2:0]     state_q, state_d;
  logic [2*W-1:0] sh_q, sh_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] alu_q, alu_d;
  logic [W-1:0]   mp_q, mp_d;
  logic [CW-1:0]  rot_q, rot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           parity_q, parity_d;
  logic           err_q, err_d;

  logic [2*W-1:0] a_x, b_x, simple_res, rot_res;
  logic [CW:0]    rot_inv;

  assign a_x = {{W{1'b0}}, a};
  assign b_x = {{W{1'b0}}, b};

  always_comb begin
    simple_res = '0;
    case (sel)
      3'b000:  simple_res = {{W{1'b0}}, ~(a & b)};
      3'b001:  simple_res = -b_x;
      3'b010:  simple_res = {a | b, a | b};
      3'b011:  simple_res = {a ^ b, ~(a | b)};
      3'b100:  simple_res = (a >= b) ? (a_x << b[SW-1:0]) : (b_x << a[SW-1:0]);
      3'b101:  simple_res = {a, b};
      default: simple_res = '0;
    endcase
  end

  // A right shift by the full width yields zero, so rotate-by-0 returns the product unchanged.
  assign rot_inv = RotFull - {1'b0, rot_q};
  assign rot_res = (acc_q << rot_q) | (acc_q >> rot_inv);

`ifdef SEQ_ALU_MOD_EN
  localparam logic [2:0]    StMod   = 3'd3;
  localparam logic [CW-1:0] ModLast = CW'(2 * W - 1);

  logic [W-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, rem_nx;
  logic [W:0]     rem_sh, rem_diff;
  logic [2*W-1:0] mod_res;

  // Restoring step: a borrow out of the top bit means the trial subtraction is discarded.
  always_comb begin
    rem_sh   = {rem_q, sh_q[2*W-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_nx   = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
    mod_res  = (b_q == '0) ? {a_q, a_q} : {{W{1'b0}}, rem_nx};
  end
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    mp_d    = mp_q;
    rot_d   = rot_q;
    cnt_d   = cnt_q;
    alu_d   = alu_q;
    err_d   = err_q;
`ifdef SEQ_ALU_MOD_EN
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          err_d = 1'b0;
          cnt_d = '0;
          case (sel)
            3'b111: begin
              state_d = StMul;
              sh_d    = a_x;
              mp_d    = b;
              acc_d   = '0;
              rot_d   = b[CW-1:0];
            end
            3'b110: begin
`ifdef SEQ_ALU_MOD_EN
              state_d = StMod;
              sh_d    = {a, a};
              rem_d   = '0;
              a_d     = a;
              b_d     = b;
`else
              state_d = StDone;
              alu_d   = '0;
              err_d   = 1'b1;
`endif
            end
            default: begin
              state_d = StDone;
              alu_d   = simple_res;
            end
          endcase
        end
      end
      StMul: begin
        if (mp_q[0]) acc_d = acc_q + sh_q;
        sh_d  = sh_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == MulLast) state_d = StRot;
      end
      StRot: begin
        alu_d   = rot_res;
        state_d = StDone;
      end
`ifdef SEQ_ALU_MOD_EN
      StMod: begin
        rem_d = rem_nx;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == ModLast) begin
          alu_d   = mod_res;
          err_d   = (b_q == '0);
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    parity_d = ^alu_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      acc_q    <= '0;
      mp_q     <= '0;
      rot_q    <= '0;
      cnt_q    <= '0;
      alu_q    <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_MOD_EN
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      mp_q     <= mp_d;
      rot_q    <= rot_d;
      cnt_q    <= cnt_d;
      alu_q    <= alu_d;
      parity_q <= parity_d;
      err_q    <= err_d;
`ifdef SEQ_ALU_MOD_EN
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign alu       = alu_q;
  assign parity    = parity_q;
  assign err       = err_q;

endmodule
